frame_tx_110: RTL and testbench

Serial frame transmitter that produces the bit stream consumed by the team's "110" sync-pattern detectors. It accepts a parallel payload word over a valid/ready handshake and emits, one bit per clock, the sync preamble 1,1,0 followed by the payload MSB-first. After the payload it emits an idle gap of zeros. It sits at the transmit end of the single-wire serial link in the sequential-misc test designs.

---
 rtl/frame_tx_pkg.sv | 20 ++
 rtl/frame_tx_110_piso_shift.sv | 28 ++
 rtl/frame_tx_110.sv | 142 ++++++++++++++
 tb/tb_frame_tx_110.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_tx_pkg.sv
// Shared types and constants for the "110" serial frame transmitter.
package frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    PAR,
    GAP
  } state_e;

  localparam logic [2:0] SYNC_PATTERN = 3'b110;
  localparam int         SYNC_LEN     = 3;

  // Counter width for counting 0..max_count-1, never narrower than 1 bit.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/frame_tx_110_piso_shift.sv
// Parallel-in serial-out shift register: load wins over shift, MSB is presented first.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] data,
  output logic         msb
);

  logic [W-1:0] shreg_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg_q <= '0;
    end else if (load) begin
      shreg_q <= data;
    end else if (shift_en) begin
      shreg_q <= shreg_q << 1;
    end
  end

  assign msb = shreg_q[W-1];

endmodule

// File: rtl/frame_tx_110.sv
// Serial frame transmitter: preamble 1,1,0, payload MSB-first, optional parity, zero gap.
// Optional even-parity bit after the payload is enabled by defining FRAME_TX_PARITY_EN.
module frame_tx_110
  import frame_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              out,
  output logic              busy,
  output logic              frame_done
);

  localparam int MAX_A   = (DATA_W > SYNC_LEN) ? DATA_W : SYNC_LEN;
  localparam int MAX_CNT = (GAP_CYCLES > MAX_A) ? GAP_CYCLES : MAX_A;
  localparam int CNT_W   = cnt_width(MAX_CNT);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // With no gap the frame ends straight into IDLE.
  localparam state_e POST_PAYLOAD = (GAP_CYCLES > 0) ? GAP : IDLE;
`ifdef FRAME_TX_PARITY_EN
  localparam state_e AFTER_DATA = PAR;
`else
  localparam state_e AFTER_DATA = POST_PAYLOAD;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             shift_msb;
  logic             out_d, busy_d, done_d, ready_d;

  assign accept = data_valid && data_ready;

  piso_shift #(.W(DATA_W)) u_piso (
    .clk      (clk),
    .rstn     (rstn),
    .load     (accept),
    .shift_en (state_d == DATA),
    .data     (data_in),
    .msb      (shift_msb)
  );

`ifdef FRAME_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^data_in;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) state_d = SYNC;
      end
      SYNC: if (cnt_q == SYNC_LAST) begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: if (cnt_q == DATA_LAST) begin
        state_d = AFTER_DATA;
        cnt_d   = '0;
      end
`ifdef FRAME_TX_PARITY_EN
      PAR: begin
        state_d = POST_PAYLOAD;
        cnt_d   = '0;
      end
`endif
      GAP: if (cnt_q == GAP_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with it.
  always_comb begin
    out_d = 1'b0;
    case (state_d)
      SYNC: begin
        for (int i = 0; i < SYNC_LEN; i++) begin
          if (cnt_d == CNT_W'(i)) out_d = |(SYNC_PATTERN & (3'b001 << (SYNC_LEN - 1 - i)));
        end
      end
      DATA:    out_d = shift_msb;
`ifdef FRAME_TX_PARITY_EN
      PAR:     out_d = par_q;
`endif
      default: out_d = 1'b0;
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    done_d  = (state_d == IDLE) && (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out        <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      data_ready <= 1'b1;
    end else begin
      out        <= out_d;
      busy       <= busy_d;
      frame_done <= done_d;
      data_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_frame_tx_110.sv
// Randomized bench for frame_tx_110: two configurations checked each cycle against a bit-stream model.
`timescale 1ns/1ps
module tb_frame_tx_110;

  localparam int W0 = 8;
  localparam int G0 = 2;
  localparam int W1 = 1;
  localparam int G1 = 0;
`ifdef FRAME_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [W0-1:0] din0 = '0;
  logic          v0 = 1'b0;
  logic [W1-1:0] din1 = '0;
  logic          v1 = 1'b0;
  logic          r0, o0, b0, d0;
  logic          r1, o1, b1, d1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  frame_tx_110 #(.DATA_W(W0), .GAP_CYCLES(G0)) u_dut (
    .clk(clk), .rstn(rstn), .data_in(din0), .data_valid(v0),
    .data_ready(r0), .out(o0), .busy(b0), .frame_done(d0)
  );

  frame_tx_110 #(.DATA_W(W1), .GAP_CYCLES(G1)) u_dut_small (
    .clk(clk), .rstn(rstn), .data_in(din1), .data_valid(v1),
    .data_ready(r1), .out(o1), .busy(b1), .frame_done(d1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each accepted word becomes a left-aligned string of line bits that is
  // played out one per clock; the line is idle (0, ready) whenever nothing is pending.
  logic [63:0] pend [2];
  int          rem [2];
  logic        exp_out [2];
  logic        exp_busy [2];
  logic        exp_done [2];
  logic        exp_ready [2];

  function automatic int frame_len(input int w, input int gap);
    return 3 + w + PAR_BITS + gap;
  endfunction

  function automatic logic [63:0] frame_bits(input logic [31:0] payload, input int w, input int gap);
    logic [63:0] v;
    logic        par;
    v   = 64'b110;
    par = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      v   = {v[62:0], payload[i]};
      par = par ^ payload[i];
    end
    if (PAR_BITS == 1) v = {v[62:0], par};
    for (int i = 0; i < gap; i++) v = {v[62:0], 1'b0};
    return v << (64 - frame_len(w, gap));
  endfunction

  task automatic step_model(input int k, input logic valid, input logic [31:0] payload,
                            input int w, input int gap);
    if (valid && exp_ready[k]) begin
      pend[k] = frame_bits(payload, w, gap);
      rem[k]  = frame_len(w, gap);
    end
    if (rem[k] > 0) begin
      exp_out[k]  = pend[k][63];
      pend[k]     = pend[k] << 1;
      rem[k]      = rem[k] - 1;
      exp_done[k] = 1'b0;
      exp_busy[k] = 1'b1;
    end else begin
      exp_done[k] = exp_busy[k];
      exp_out[k]  = 1'b0;
      exp_busy[k] = 1'b0;
    end
    exp_ready[k] = !exp_busy[k];
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin
        pend[k]      = '0;
        rem[k]       = 0;
        exp_out[k]   = 1'b0;
        exp_busy[k]  = 1'b0;
        exp_done[k]  = 1'b0;
        exp_ready[k] = 1'b1;
      end
    end else begin
      step_model(0, v0, 32'(din0), W0, G0);
      step_model(1, v1, 32'(din1), W1, G1);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out",         32'(o0), 32'(exp_out[0]));
      check("busy",        32'(b0), 32'(exp_busy[0]));
      check("frame_done",  32'(d0), 32'(exp_done[0]));
      check("data_ready",  32'(r0), 32'(exp_ready[0]));
      check("s_out",       32'(o1), 32'(exp_out[1]));
      check("s_busy",      32'(b1), 32'(exp_busy[1]));
      check("s_frame_done",32'(d1), 32'(exp_done[1]));
      check("s_data_ready",32'(r1), 32'(exp_ready[1]));
    end
  end

  // Offer a word to DUT k and return at the posedge that accepts it.
  task automatic send(input int k, input logic [31:0] word, input bit keep_valid);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    if (k == 0) begin v0 = 1'b1; din0 = W0'(word); end
    else        begin v1 = 1'b1; din1 = W1'(word); end
    for (int n = 0; n < 100; n++) begin
      acc = (k == 0) ? r0 : r1;
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    check("accept", 32'(acc), 32'd1);
    if (!keep_valid) begin
      @(negedge clk);
      if (k == 0) v0 = 1'b0;
      else        v1 = 1'b0;
    end
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    #2 rstn = 1'b1;

    // Quiet line after reset.
    repeat (20) @(negedge clk);

    send(0, 32'hA5, 1'b0);
    repeat (16) @(negedge clk);

    // Valid held across two words: second accepted on the frame_done cycle.
    send(0, 32'hFF, 1'b1);
    send(0, 32'h00, 1'b0);
    repeat (16) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      send(0, $urandom, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    @(negedge clk);
    v0 = 1'b0;
    repeat (16) @(negedge clk);

    // Abort mid-payload: the line must drop without waiting for a clock edge.
    send(0, 32'hFF, 1'b0);
    repeat (6) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_out",   32'(o0), 32'd0);
    check("async_busy",  32'(b0), 32'd0);
    check("async_ready", 32'(r0), 32'd1);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    repeat (10) @(negedge clk);
    send(0, 32'h3C, 1'b0);
    repeat (16) @(negedge clk);

    // One-bit payload, no gap.
    send(1, 32'h1, 1'b0);
    repeat (6) @(negedge clk);
    send(1, 32'h0, 1'b0);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      send(1, $urandom, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    v1 = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
